// File: rtl/down_timer.sv
// down_timer: reloadable down counter with one-shot/periodic modes, pause/resume and a sticky expired flag
module down_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         start,
  input  logic         stop,
  input  logic         periodic,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         bo,
  output logic         busy,
  output logic         running,
  output logic         expired
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t       state, state_n;
  logic [W-1:0] cnt_n, reload;
  logic         mode, mode_n;
  assign bo      = (state == RUN) & en & (cnt == '0);
  assign busy    = state != IDLE;
  assign running = state == RUN;
  // next state, count and mode; terminal count takes priority over stop in RUN
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mode_n  = mode;
    case (state)
      IDLE: begin
        if (load) cnt_n = load_val;
        if (start && !stop) begin
          state_n = RUN;
          cnt_n   = load ? load_val : reload;
          mode_n  = periodic;
        end
      end
      RUN: begin
        if (bo) begin
          cnt_n   = mode ? reload : '0;
          state_n = !mode ? IDLE : stop ? PAUSE : RUN;
        end else if (stop) state_n = PAUSE;
        else if (en) cnt_n = cnt - W'(1);
      end
      PAUSE: state_n = stop ? IDLE : start ? RUN : PAUSE;
      default: state_n = IDLE;
    endcase
  end
  // state registers; reset discards any count in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      reload  <= '0;
      mode    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      mode    <= mode_n;
      reload  <= load ? load_val : reload;
      expired <= bo | (expired & ~clr);
    end
  end
endmodule
